// File: rtl/gravsim_pkg.sv
// Shared definitions for the gravity simulator datapath: Q16.16 width,
// regfile word offsets (shared with avalon_interface) and the integrator state enum.
package gravsim_pkg;

    localparam int unsigned QW = 32;
    localparam int unsigned AW = 7;

    localparam logic [AW-1:0] OFFSET_POS_X = 7'd24;
    localparam logic [AW-1:0] OFFSET_POS_Y = 7'd34;
    localparam logic [AW-1:0] OFFSET_POS_Z = 7'd44;
    localparam logic [AW-1:0] OFFSET_VEL_X = 7'd54;
    localparam logic [AW-1:0] OFFSET_VEL_Y = 7'd64;
    localparam logic [AW-1:0] OFFSET_VEL_Z = 7'd74;
    localparam logic [AW-1:0] OFFSET_ACC_X = 7'd84;
    localparam logic [AW-1:0] OFFSET_ACC_Y = 7'd94;
    localparam logic [AW-1:0] OFFSET_ACC_Z = 7'd104;

    typedef enum logic [2:0] {
        StIdle,
        StRdAv,
        StWaitAv,
        StWrV,
        StRdP,
        StWaitP,
        StWrP,
        StDone
    } integ_state_e;

endpackage

// File: rtl/euler_integrator_sat.sv
// Combinational y = sat(a + (b >>> shift)) on signed fixed-point words,
// clamping to the most positive / most negative value instead of wrapping.
module sat_shift_add
    import gravsim_pkg::*;
#(
    parameter int unsigned W = QW
) (
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [$clog2(W)-1:0] shift,
    output logic [W-1:0]         y
);

    logic signed [W-1:0] b_sh;
    logic signed [W:0]   sum;

    always_comb begin
        b_sh = $signed(b) >>> shift;
        sum  = $signed({a[W-1], a}) + $signed({b_sh[W-1], b_sh});
        // Top two bits disagree only when the W-bit result overflowed.
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/euler_integrator.sv
// Semi-implicit Euler integration pass over the regfile: for each body,
// v' = sat(v + a*dt) is written back, then p' = sat(p + v'*dt).
module euler_integrator
    import gravsim_pkg::*;
#(
    parameter int unsigned DT_SHIFT   = 8,
    parameter int unsigned MAX_BODIES = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [6:0]    PLANET_NUM,
    output logic          DONE,
    output logic          BUSY,
    output logic [1:0]    FSM_re,
    output logic [1:0]    FSM_we,
    output logic [6:0]    ADDR1,
    output logic [6:0]    ADDR2,
    output logic [6:0]    ADDR3,
    output logic [6:0]    ADDR4,
    output logic [6:0]    ADDR5,
    output logic [6:0]    ADDR6,
    output logic [31:0]   DATA1,
    output logic [31:0]   DATA2,
    output logic [31:0]   DATA3,
    output logic [31:0]   DATA4,
    output logic [31:0]   DATA5,
    output logic [31:0]   DATA6,
    input  logic [31:0]   DATA1in,
    input  logic [31:0]   DATA2in,
    input  logic [31:0]   DATA3in,
    input  logic [31:0]   DATA4in,
    input  logic [31:0]   DATA5in,
    input  logic [31:0]   DATA6in
);

    localparam int unsigned     SW    = $clog2(QW);
    localparam logic [SW-1:0]   SHIFT = SW'(DT_SHIFT);
    localparam logic [AW-1:0]   MAX_N = AW'(MAX_BODIES);

    localparam logic [AW-1:0] POS_OFF [3] = '{OFFSET_POS_X, OFFSET_POS_Y, OFFSET_POS_Z};
    localparam logic [AW-1:0] VEL_OFF [3] = '{OFFSET_VEL_X, OFFSET_VEL_Y, OFFSET_VEL_Z};
    localparam logic [AW-1:0] ACC_OFF [3] = '{OFFSET_ACC_X, OFFSET_ACC_Y, OFFSET_ACC_Z};

    integ_state_e    state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   neff_q, neff_d, neff_in;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [1:0]      re_q, re_d;
    logic [1:0]      we_q, we_d;
    logic [AW-1:0]   addr_q [6];
    logic [AW-1:0]   addr_d [6];
    logic [QW-1:0]   data_q [6];
    logic [QW-1:0]   data_d [6];
    logic [QW-1:0]   vnew_q [3];
    logic [QW-1:0]   vnew_d [3];
    logic [QW-1:0]   din    [6];
    logic [QW-1:0]   sa_b   [3];
    logic [QW-1:0]   sa_y   [3];

    assign din[0] = DATA1in;
    assign din[1] = DATA2in;
    assign din[2] = DATA3in;
    assign din[3] = DATA4in;
    assign din[4] = DATA5in;
    assign din[5] = DATA6in;

    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign FSM_re = re_q;
    assign FSM_we = we_q;
    assign ADDR1  = addr_q[0];
    assign ADDR2  = addr_q[1];
    assign ADDR3  = addr_q[2];
    assign ADDR4  = addr_q[3];
    assign ADDR5  = addr_q[4];
    assign ADDR6  = addr_q[5];
    assign DATA1  = data_q[0];
    assign DATA2  = data_q[1];
    assign DATA3  = data_q[2];
    assign DATA4  = data_q[3];
    assign DATA5  = data_q[4];
    assign DATA6  = data_q[5];

    assign neff_in = (PLANET_NUM > MAX_N) ? MAX_N : PLANET_NUM;

    // The three saturating adders serve the velocity step (b = acc) and the
    // position step (b = v'), selected by which read is being consumed.
    for (genvar k = 0; k < 3; k++) begin : g_sat
        sat_shift_add #(
            .W (QW)
        ) u_sat (
            .a     (din[k]),
            .b     (sa_b[k]),
            .shift (SHIFT),
            .y     (sa_y[k])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        neff_d  = neff_q;
        addr_d  = addr_q;
        data_d  = data_q;
        vnew_d  = vnew_q;
        re_d    = 2'd0;
        we_d    = 2'd0;

        for (int k = 0; k < 3; k++) begin
            sa_b[k] = (state_q == StWaitP) ? vnew_q[k] : din[k+3];
        end

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    idx_d   = '0;
                    neff_d  = neff_in;
                    state_d = (neff_in == '0) ? StDone : StRdAv;
                end
            end
            StRdAv:   state_d = StWaitAv;
            StWaitAv: begin
                vnew_d  = sa_y;
                state_d = StWrV;
            end
            StWrV:    state_d = StRdP;
            StRdP:    state_d = StWaitP;
            StWaitP:  state_d = StWrP;
            StWrP: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == neff_q - 1'b1) ? StDone : StRdAv;
            end
            StDone: begin
                // Stay at least one cycle so DONE is seen even if START already fell.
                if (!START && done_q) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase

        // Bus outputs are registered against the state being entered.
        unique case (state_d)
            StRdAv: begin
                re_d = 2'd3;
                for (int k = 0; k < 3; k++) begin
                    addr_d[k]   = VEL_OFF[k] + idx_d;
                    addr_d[k+3] = ACC_OFF[k] + idx_d;
                end
            end
            StWrV: begin
                we_d = 2'd1;
                for (int k = 0; k < 3; k++) begin
                    addr_d[k] = VEL_OFF[k] + idx_d;
                    data_d[k] = sa_y[k];
                end
            end
            StRdP: begin
                re_d = 2'd1;
                for (int k = 0; k < 3; k++) begin
                    addr_d[k] = POS_OFF[k] + idx_d;
                end
            end
            StWrP: begin
                we_d = 2'd1;
                for (int k = 0; k < 3; k++) begin
                    data_d[k] = sa_y[k];
                end
            end
            default: ;
        endcase

        busy_d = (state_d != StIdle) && (state_d != StDone);
        done_d = (state_q == StDone) && (state_d == StDone);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            neff_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            re_q    <= 2'd0;
            we_q    <= 2'd0;
            for (int k = 0; k < 6; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                vnew_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            neff_q  <= neff_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            re_q    <= re_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            vnew_q  <= vnew_d;
        end
    end

endmodule

// File: tb/tb_euler_integrator.sv
// Bench for euler_integrator: regfile model with registered reads, and a
// plain-arithmetic Euler reference applied to a snapshot of the regfile.
module tb_euler_integrator;

    localparam int DT   = 8;
    localparam int MAXB = 10;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [6:0]  PLANET_NUM;
    logic        DONE, BUSY;
    logic [1:0]  FSM_re, FSM_we;
    logic [6:0]  ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
    logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
    logic [31:0] rd [6];

    logic [31:0] mem      [128];
    logic [31:0] init_mem [128];
    logic [31:0] exp_mem  [128];
    logic        load;
    logic        mon_clr;
    int          act_cnt = 0;
    int          both_cnt = 0;
    logic [6:0]  max_raddr = '0;

    int n_checks = 0;
    int n_pass   = 0;

    euler_integrator #(
        .DT_SHIFT   (DT),
        .MAX_BODIES (MAXB)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .PLANET_NUM (PLANET_NUM),
        .DONE       (DONE),
        .BUSY       (BUSY),
        .FSM_re     (FSM_re),
        .FSM_we     (FSM_we),
        .ADDR1      (ADDR1),
        .ADDR2      (ADDR2),
        .ADDR3      (ADDR3),
        .ADDR4      (ADDR4),
        .ADDR5      (ADDR5),
        .ADDR6      (ADDR6),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .DATA3      (DATA3),
        .DATA4      (DATA4),
        .DATA5      (DATA5),
        .DATA6      (DATA6),
        .DATA1in    (rd[0]),
        .DATA2in    (rd[1]),
        .DATA3in    (rd[2]),
        .DATA4in    (rd[3]),
        .DATA5in    (rd[4]),
        .DATA6in    (rd[5])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Regfile: registered reads, writes on the edge that sees FSM_we.
    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
        end else begin
            if (FSM_we != 2'd0) begin
                mem[ADDR1] <= DATA1;
                mem[ADDR2] <= DATA2;
                mem[ADDR3] <= DATA3;
                if (FSM_we == 2'd3) begin
                    mem[ADDR4] <= DATA4;
                    mem[ADDR5] <= DATA5;
                    mem[ADDR6] <= DATA6;
                end
            end
            if (FSM_re != 2'd0) begin
                rd[0] <= mem[ADDR1];
                rd[1] <= mem[ADDR2];
                rd[2] <= mem[ADDR3];
                if (FSM_re == 2'd3) begin
                    rd[3] <= mem[ADDR4];
                    rd[4] <= mem[ADDR5];
                    rd[5] <= mem[ADDR6];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (FSM_re != 2'd0 || FSM_we != 2'd0) act_cnt++;
        if (FSM_re != 2'd0 && FSM_we != 2'd0) both_cnt++;
        if (mon_clr) max_raddr = '0;
        else if (FSM_re == 2'd3 && ADDR6 > max_raddr) max_raddr = ADDR6;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_sat(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + (longint'($signed(b)) >>> DT);
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic build_expected(input int n);
        int nb;
        logic [31:0] v;
        exp_mem = init_mem;
        nb = (n > MAXB) ? MAXB : n;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < 3; c++) begin
                v = ref_sat(init_mem[54 + 10*c + i], init_mem[84 + 10*c + i]);
                exp_mem[54 + 10*c + i] = v;
                exp_mem[24 + 10*c + i] = ref_sat(init_mem[24 + 10*c + i], v);
            end
        end
    endtask

    task automatic load_regfile();
        @(negedge CLK);
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 128; i++) init_mem[i] = rnd ? $urandom : 32'd0;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 24; a < 114; a++) begin
            check($sformatf("%s mem[%0d]", tag, a), 64'(mem[a]), 64'(exp_mem[a]));
        end
    endtask

    // START rises at a negedge; the following posedge is edge 0.
    task automatic run_pass(input int n, input string tag, input bit drop);
        int edges;
        int nb;
        int a0;
        nb = (n > MAXB) ? MAXB : n;
        PLANET_NUM = 7'(n);
        build_expected(n);
        a0 = act_cnt;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        edges = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (k == 1 && nb > 0) check({tag, " busy"}, 64'(BUSY), 64'd1);
            if (DONE) begin
                edges = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(edges), 64'(6 * nb + 1));
        check({tag, " busy@done"}, 64'(BUSY), 64'd0);
        if (nb == 0) check({tag, " no bus activity"}, 64'(act_cnt - a0), 64'd0);
        else check({tag, " bus cycles"}, 64'(act_cnt - a0), 64'(4 * nb));
        check_mem(tag);
        if (drop) begin
            START = 1'b0;
            @(negedge CLK);
            check({tag, " done drop"}, 64'(DONE), 64'd0);
        end
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        PLANET_NUM = '0;
        load = 1'b0;
        mon_clr = 1'b0;
        fill(1'b0);
        repeat (3) @(negedge CLK);
        check("rst done", 64'(DONE), 64'd0);
        check("rst busy", 64'(BUSY), 64'd0);
        check("rst re", 64'(FSM_re), 64'd0);
        check("rst we", 64'(FSM_we), 64'd0);
        check("rst addr", 64'({ADDR1, ADDR6}), 64'd0);
        check("rst data", 64'({DATA1, DATA6}), 64'd0);
        RESET = 1'b0;
        load_regfile();

        // Single body, unit acceleration.
        fill(1'b0);
        init_mem[84] = 32'h0001_0000;
        load_regfile();
        run_pass(1, "n1", 1'b1);
        check("n1 v'", 64'(mem[54]), 64'h0000_0100);
        check("n1 p'", 64'(mem[24]), 64'h0000_0001);

        // Zero bodies.
        fill(1'b1);
        load_regfile();
        run_pass(0, "n0", 1'b1);

        // Clamped body count.
        fill(1'b1);
        load_regfile();
        mon_clr = 1'b1;
        repeat (2) @(negedge CLK);
        mon_clr = 1'b0;
        run_pass(15, "n15", 1'b1);
        check("n15 max read addr", 64'(max_raddr), 64'd113);

        // Positive and negative saturation.
        fill(1'b0);
        init_mem[24] = 32'h7FFF_FF00;
        init_mem[54] = 32'h0100_0000;
        init_mem[55] = 32'h8000_0010;
        init_mem[85] = 32'hF000_0000;
        load_regfile();
        run_pass(2, "sat", 1'b1);
        check("sat p' max", 64'(mem[24]), 64'h7FFF_FFFF);
        check("sat v' min", 64'(mem[55]), 64'h8000_0000);

        // Reset during the velocity write of body 2.
        fill(1'b1);
        load_regfile();
        PLANET_NUM = 7'd5;
        build_expected(2);
        for (int c = 0; c < 3; c++) begin
            exp_mem[56 + 10*c] = ref_sat(init_mem[56 + 10*c], init_mem[86 + 10*c]);
        end
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        check("abort in wr_v", 64'(FSM_we), 64'd1);
        check("abort wr_v addr", 64'(ADDR1), 64'd56);
        RESET = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        check("abort re", 64'(FSM_re), 64'd0);
        check("abort we", 64'(FSM_we), 64'd0);
        check("abort busy", 64'(BUSY), 64'd0);
        check("abort done", 64'(DONE), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check_mem("abort");

        // START held after DONE must not retrigger.
        fill(1'b1);
        load_regfile();
        run_pass(3, "hold", 1'b0);
        begin
            int a0;
            a0 = act_cnt;
            repeat (20) @(negedge CLK);
            check("hold done", 64'(DONE), 64'd1);
            check("hold no retrigger", 64'(act_cnt - a0), 64'd0);
        end
        START = 1'b0;
        @(negedge CLK);
        check("hold drop done", 64'(DONE), 64'd0);
        init_mem = mem;
        run_pass(3, "rerun", 1'b1);

        // Randomized passes.
        for (int r = 0; r < 6; r++) begin
            fill(1'b1);
            load_regfile();
            run_pass(int'($urandom_range(0, 13)), $sformatf("rnd%0d", r), 1'b1);
        end

        check("re/we exclusive", 64'(both_cnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
